// File: rtl/dsi_packet_assembler_pkg.sv
// Shared types, DSI constants and header ECC for the DSI packet assembler.
package dsi_packet_assembler_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPayload,
        StCrcLo,
        StCrcHi
    } state_e;

    localparam logic [5:0]  DT_DCS_SHORT_WR = 6'h05;
    localparam logic [5:0]  DT_DCS_LONG_WR  = 6'h39;
    localparam logic [15:0] CRC_SEED        = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL   = 16'h8408;

    // d = {WC[15:8], WC[7:0], DI}; returns {2'b00, P5..P0}
    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
             ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
             ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18]
             ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

endpackage

// File: rtl/dsi_packet_assembler_crc16.sv
// Byte-wide CRC-16 (x^16+x^12+x^5+1, LSB-first) next-state function.
module dsi_crc16
    import dsi_packet_assembler_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    always_comb begin
        logic [15:0] c;
        c = crc_i ^ {8'h00, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/dsi_packet_assembler.sv
// Serialises DSI short/long packets into the dsi_lane byte handshake, adding ECC and CRC.
module dsi_packet_assembler
    import dsi_packet_assembler_pkg::*;
#(
    parameter bit CRC_EN = 1'b1,
    parameter bit ECC_EN = 1'b1
) (
    input  logic        clk_base,
    input  logic        reset_n,
    input  logic        pkt_valid_i,
    output logic        pkt_ready_o,
    input  logic        pkt_long_i,
    input  logic        pkt_hs_i,
    input  logic [7:0]  pkt_di_i,
    input  logic [15:0] pkt_wc_i,
    input  logic        pl_valid_i,
    input  logic [7:0]  pl_data_i,
    output logic        pl_ready_o,
    input  logic        lane_data_ready_i,
    output logic        lane_data_write_o,
    output logic [7:0]  lane_data_o,
    output logic        lane_data_type_o,
    output logic        lane_end_of_frame_o,
    output logic        lane_dummy_frame_o,
    output logic        busy_o
);

    state_e      state_q;
    logic [1:0]  byte_idx_q;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic        long_q;
    logic        hs_q;
    logic [7:0]  ecc_q;
    logic [15:0] cnt_q;
    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] crc_out;
    logic        write;
    logic [7:0]  byte_mux;

    dsi_crc16 u_crc (
        .crc_i  (crc_q),
        .data_i (pl_data_i),
        .crc_o  (crc_d)
    );

    assign crc_out = CRC_EN ? crc_q : 16'h0000;

    always_comb begin
        busy_o      = (state_q != StIdle);
        pkt_ready_o = (state_q == StIdle);
        pl_ready_o  = (state_q == StPayload) && lane_data_ready_i;
        write       = busy_o && lane_data_ready_i && ((state_q != StPayload) || pl_valid_i);

        byte_mux = 8'h00;
        unique case (state_q)
            StHdr: begin
                unique case (byte_idx_q)
                    2'd0: byte_mux = di_q;
                    2'd1: byte_mux = wc_q[7:0];
                    2'd2: byte_mux = wc_q[15:8];
                    2'd3: byte_mux = ecc_q;
                endcase
            end
            StPayload: byte_mux = pl_data_i;
            StCrcLo:   byte_mux = crc_out[7:0];
            StCrcHi:   byte_mux = crc_out[15:8];
            default:   byte_mux = 8'h00;
        endcase

        lane_data_write_o   = write;
        lane_dummy_frame_o  = write;
        lane_data_o         = write ? byte_mux : 8'h00;
        lane_data_type_o    = busy_o && hs_q;
        lane_end_of_frame_o = write && (((state_q == StHdr) && (byte_idx_q == 2'd3) && !long_q)
                                        || (state_q == StCrcHi));
    end

    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            byte_idx_q <= 2'd0;
            di_q       <= 8'h00;
            wc_q       <= 16'h0000;
            long_q     <= 1'b0;
            hs_q       <= 1'b0;
            ecc_q      <= 8'h00;
            cnt_q      <= 16'h0000;
            crc_q      <= 16'h0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pkt_valid_i) begin
                        di_q       <= pkt_di_i;
                        wc_q       <= pkt_wc_i;
                        long_q     <= pkt_long_i;
                        hs_q       <= pkt_hs_i;
                        ecc_q      <= ECC_EN ? dsi_ecc({pkt_wc_i, pkt_di_i}) : 8'h00;
                        crc_q      <= CRC_SEED;
                        byte_idx_q <= 2'd0;
                        state_q    <= StHdr;
                    end
                end
                StHdr: begin
                    if (write) begin
                        if (byte_idx_q == 2'd3) begin
                            if (!long_q) begin
                                state_q <= StIdle;
                            end else if (wc_q == 16'h0000) begin
                                state_q <= StCrcLo;
                            end else begin
                                cnt_q   <= wc_q;
                                state_q <= StPayload;
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                StPayload: begin
                    if (write) begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_q <= StCrcLo;
                        end
                    end
                end
                StCrcLo: begin
                    if (write) begin
                        state_q <= StCrcHi;
                    end
                end
                StCrcHi: begin
                    if (write) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
